// File: rtl/rf_wb_pkg.sv
// rtl/rf_wb_pkg.sv - Register-bank constants and address/data types for the write-back path
package rf_wb_pkg;
  localparam int RF_AW      = 5;
  localparam int RF_DW      = 32;
  localparam int RF_NREGS   = 32;
  localparam int RF_SP_IDX  = 29;
  localparam int RF_RET_IDX = 1;

  typedef logic [RF_AW-1:0] rf_addr_t;
  typedef logic [RF_DW-1:0] rf_data_t;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - Decode, requester and bank-write signals of the write-back arbiter
import rf_wb_pkg::*;

interface rf_wb_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW
);
  logic              issue_valid;
  logic [AW-1:0]     issue_reg;
  logic              issue_ready;
  logic [AW-1:0]     rd_rs;
  logic [AW-1:0]     rd_rt;
  logic              stall;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*AW-1:0] req_reg;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [DW-1:0]     rf_wdata;
  logic [2**AW-1:0]  busy_vec;

  modport master (
    output issue_valid, issue_reg, rd_rs, rd_rt, req_valid, req_reg, req_data,
    input  issue_ready, stall, req_ready, rf_we, rf_waddr, rf_wdata, busy_vec
  );

  modport slave (
    input  issue_valid, issue_reg, rd_rs, rd_rt, req_valid, req_reg, req_data,
    output issue_ready, stall, req_ready, rf_we, rf_waddr, rf_wdata, busy_vec
  );
endinterface

// File: rtl/rf_wb_arbiter_rr.sv
// rtl/rf_wb_arbiter_rr.sv - Round-robin one-hot grant starting the search at ptr
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   gnt_idx,
  output logic            gnt_valid
);
  logic [PW-1:0] idx;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt[idx]  = 1'b1;
        gnt_idx   = idx;
      end
    end
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - Write-back arbiter, registered bank write and pending-write scoreboard
// Optional RF_WB_ZERO_DROP_EN: accept but drop writes to register 0, never mark it busy.
import rf_wb_pkg::*;

module rf_wb_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW
) (
  input logic            clk,
  input logic            rst,
  rf_wb_arbiter_if.slave bus
);
  localparam int NREGS = 2**AW;
  localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]    ptr;
  logic [PW-1:0]    gnt_idx;
  logic [NREQ-1:0]  gnt;
  logic             gnt_valid;
  logic [AW-1:0]    gnt_reg;
  logic [DW-1:0]    gnt_data;
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic             ret_valid;
  logic [AW-1:0]    ret_addr;
  logic             issue_ok;
  logic             issue_set;
  logic             wr_emit;
  logic             rs_hit;
  logic             rt_hit;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
    .req       (bus.req_valid),
    .ptr       (ptr),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  assign bus.req_ready = gnt;
  assign gnt_reg       = bus.req_reg[int'(gnt_idx)*AW +: AW];
  assign gnt_data      = bus.req_data[int'(gnt_idx)*DW +: DW];

  // A busy destination blocks the issue (WAW) until its write retires
  assign issue_ok        = bus.issue_valid & ~busy[bus.issue_reg];
  assign bus.issue_ready = issue_ok;

`ifdef RF_WB_ZERO_DROP_EN
  assign issue_set = issue_ok & (bus.issue_reg != '0);
  assign wr_emit   = gnt_valid & (gnt_reg != '0);
`else
  assign issue_set = issue_ok;
  assign wr_emit   = gnt_valid;
`endif

  // The retiring shadow covers the cycle the bank write is still in flight
  assign rs_hit    = (bus.rd_rs != '0) & (busy[bus.rd_rs] | (ret_valid & (ret_addr == bus.rd_rs)));
  assign rt_hit    = (bus.rd_rt != '0) & (busy[bus.rd_rt] | (ret_valid & (ret_addr == bus.rd_rt)));
  assign bus.stall = rs_hit | rt_hit;

  always_comb begin
    busy_nxt = busy;
    if (gnt_valid) busy_nxt[gnt_reg] = 1'b0;
    if (issue_set) busy_nxt[bus.issue_reg] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr          <= '0;
      busy         <= '0;
      ret_valid    <= 1'b0;
      ret_addr     <= '0;
      bus.rf_we    <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
    end else begin
      busy      <= busy_nxt;
      ret_valid <= gnt_valid;
      bus.rf_we <= wr_emit;
      if (gnt_valid) begin
        ret_addr <= gnt_reg;
        ptr      <= (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      end
      if (wr_emit) begin
        bus.rf_waddr <= gnt_reg;
        bus.rf_wdata <= gnt_data;
      end
    end
  end

  assign bus.busy_vec = busy;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - Self-checking bench: directed tables and sequences plus randomized model comparison
import rf_wb_pkg::*;

module tb_rf_wb_arbiter;
  localparam int NREQ = 2;
  localparam int AW   = 5;
  localparam int DW   = 32;
`ifdef RF_WB_ZERO_DROP_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_wb_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();
  rf_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  exp_ready;
    logic        exp_we;
    rf_addr_t    exp_addr;
    logic [31:0] exp_data;
  } rr_vec_t;
  rr_vec_t tbl[8];

  // Reference model state
  logic [31:0] mbusy;
  int          mptr;
  bit          mret_v;
  rf_addr_t    mret_a;
  logic        mwe;
  rf_addr_t    mwa;
  logic [31:0] mwd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0;
    bus.issue_reg   = '0;
    bus.rd_rs       = '0;
    bus.rd_rt       = '0;
    bus.req_valid   = '0;
    bus.req_reg     = '0;
    bus.req_data    = '0;
  endtask

  task automatic set_req(input int i, input logic v, input rf_addr_t r, input logic [31:0] d);
    bus.req_valid[i]        = v;
    bus.req_reg[i*AW +: AW] = r;
    bus.req_data[i*DW +: DW] = d;
  endtask

  function automatic bit pend(input rf_addr_t a);
    return (a != 0) && (mbusy[a] || (mret_v && mret_a == a));
  endfunction

  initial begin
    int g;
    rf_addr_t gr;
    logic [31:0] gd;
    logic [1:0] rv;

    tbl[0] = '{2'b11, 2'b01, 1'b1, 5'd3, 32'hA};
    tbl[1] = '{2'b11, 2'b10, 1'b1, 5'd4, 32'hB};
    tbl[2] = '{2'b11, 2'b01, 1'b1, 5'd3, 32'hA};
    tbl[3] = '{2'b11, 2'b10, 1'b1, 5'd4, 32'hB};
    tbl[4] = '{2'b00, 2'b00, 1'b0, 5'd4, 32'hB};
    tbl[5] = '{2'b10, 2'b10, 1'b1, 5'd4, 32'hB};
    tbl[6] = '{2'b01, 2'b01, 1'b1, 5'd3, 32'hA};
    tbl[7] = '{2'b11, 2'b10, 1'b1, 5'd4, 32'hB};

    // Reset
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_we", bus.rf_we, 0);
    chk("rst_waddr", bus.rf_waddr, 0);
    chk("rst_wdata", bus.rf_wdata, 0);
    chk("rst_busy", bus.busy_vec, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_ready", bus.req_ready, 0);

    // Round-robin table
    for (int n = 0; n < 8; n++) begin
      set_req(0, tbl[n].valid[0], 5'd3, 32'hA);
      set_req(1, tbl[n].valid[1], 5'd4, 32'hB);
      #1;
      chk($sformatf("rr_ready[%0d]", n), bus.req_ready, tbl[n].exp_ready);
      tick();
      chk($sformatf("rr_we[%0d]", n), bus.rf_we, tbl[n].exp_we);
      chk($sformatf("rr_waddr[%0d]", n), bus.rf_waddr, tbl[n].exp_addr);
      chk($sformatf("rr_wdata[%0d]", n), bus.rf_wdata, tbl[n].exp_data);
    end
    idle();

    // Scoreboard stall with one-cycle retiring shadow
    bus.issue_valid = 1'b1;
    bus.issue_reg   = 5'd5;
    #1;
    chk("sb_issue_ready", bus.issue_ready, 1);
    tick();
    bus.issue_valid = 1'b0;
    bus.rd_rs       = 5'd5;
    #1;
    chk("sb_stall_pending", bus.stall, 1);
    chk("sb_busy5", bus.busy_vec, 32'h20);
    set_req(0, 1'b1, 5'd5, 32'h55);
    #1;
    chk("sb_stall_t", bus.stall, 1);
    tick();
    set_req(0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("sb_we_t1", bus.rf_we, 1);
    chk("sb_waddr_t1", bus.rf_waddr, 5);
    chk("sb_wdata_t1", bus.rf_wdata, 32'h55);
    chk("sb_stall_t1", bus.stall, 1);
    chk("sb_busy_t1", bus.busy_vec, 0);
    tick();
    chk("sb_stall_t2", bus.stall, 0);
    chk("sb_we_t2", bus.rf_we, 0);
    idle();

    // WAW block
    bus.issue_valid = 1'b1;
    bus.issue_reg   = 5'd7;
    #1;
    chk("waw_first", bus.issue_ready, 1);
    tick();
    chk("waw_block0", bus.issue_ready, 0);
    tick();
    set_req(1, 1'b1, 5'd7, 32'h70);
    #1;
    chk("waw_block1", bus.issue_ready, 0);
    tick();
    set_req(1, 1'b0, 5'd0, 32'h0);
    #1;
    chk("waw_release", bus.issue_ready, 1);
    tick();
    bus.issue_valid = 1'b0;
    chk("waw_busy7", bus.busy_vec, 32'h80);

    // Same-cycle issue set and grant clear on register 9: set wins
    bus.issue_valid = 1'b1;
    bus.issue_reg   = 5'd9;
    set_req(0, 1'b1, 5'd9, 32'h99);
    #1;
    chk("sim_issue_ready", bus.issue_ready, 1);
    chk("sim_req_ready", bus.req_ready, 2'b01);
    tick();
    chk("sim_busy", bus.busy_vec, 32'h280);
    chk("sim_waddr", bus.rf_waddr, 9);
    // With 9 pending the issue is refused; only the clear lands
    chk("sim_issue_block", bus.issue_ready, 0);
    tick();
    chk("sim_busy_clear", bus.busy_vec, 32'h80);
    idle();

    // Reset mid-operation: leave ptr at 1, then reset with both requests pending
    bus.issue_valid = 1'b1;
    bus.issue_reg   = 5'd12;
    set_req(0, 1'b1, 5'd20, 32'h77);
    tick();
    idle();
    rst = 1'b1;
    set_req(0, 1'b1, 5'd21, 32'h21);
    set_req(1, 1'b1, 5'd22, 32'h22);
    tick();
    rst = 1'b0;
    chk("mid_we", bus.rf_we, 0);
    chk("mid_busy", bus.busy_vec, 0);
    chk("mid_ptr", bus.req_ready, 2'b01);
    tick();
    chk("mid_waddr", bus.rf_waddr, 21);
    idle();

    // Register 0 write and issue
    set_req(0, 1'b1, 5'd0, 32'hFF);
    bus.issue_valid = 1'b1;
    bus.issue_reg   = 5'd0;
    #1;
    chk("zero_ready", bus.req_ready, 2'b01);
    chk("zero_issue_ready", bus.issue_ready, 1);
    tick();
    idle();
    #1;
    chk("zero_we", bus.rf_we, ZD ? 1'b0 : 1'b1);
    chk("zero_waddr", bus.rf_waddr, ZD ? 5'd21 : 5'd0);
    chk("zero_wdata", bus.rf_wdata, ZD ? 32'h21 : 32'hFF);
    chk("zero_busy", bus.busy_vec, ZD ? 32'h0 : 32'h1);
    chk("zero_stall", bus.stall, 0);

    // Randomized against the reference model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mbusy = '0; mptr = 0; mret_v = 0; mret_a = '0; mwe = 0; mwa = '0; mwd = '0;
    for (int n = 0; n < 300; n++) begin
      rst = ($urandom_range(39) == 0);
      rv = 2'($urandom_range(3));
      bus.req_valid = rv;
      for (int i = 0; i < NREQ; i++) begin
        bus.req_reg[i*AW +: AW]  = AW'($urandom_range(7));
        bus.req_data[i*DW +: DW] = $urandom;
      end
      bus.issue_valid = 1'($urandom_range(1));
      bus.issue_reg   = AW'($urandom_range(7));
      bus.rd_rs       = AW'($urandom_range(7));
      bus.rd_rt       = AW'($urandom_range(7));

      g = -1;
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && ((rv >> ((mptr + k) % NREQ)) & 2'b01) != 0) g = (mptr + k) % NREQ;
      gr = (g >= 0) ? AW'(bus.req_reg >> (g*AW)) : '0;
      gd = (g >= 0) ? DW'(bus.req_data >> (g*DW)) : '0;
      #1;
      chk($sformatf("rnd_ready[%0d]", n), bus.req_ready, (g >= 0) ? (2'b01 << g) : 2'b00);
      chk($sformatf("rnd_issue[%0d]", n), bus.issue_ready, bus.issue_valid && !mbusy[bus.issue_reg]);
      chk($sformatf("rnd_stall[%0d]", n), bus.stall, pend(bus.rd_rs) || pend(bus.rd_rt));

      if (rst) begin
        mbusy = '0; mptr = 0; mret_v = 0; mret_a = '0; mwe = 0; mwa = '0; mwd = '0;
      end else begin
        bit iss;
        iss = bus.issue_valid && !mbusy[bus.issue_reg];
        mret_v = (g >= 0);
        if (g >= 0) begin
          mret_a = gr;
          mbusy[gr] = 1'b0;
          mptr = (g + 1) % NREQ;
        end
        mwe = (g >= 0) && !(ZD && gr == 0);
        if (mwe) begin
          mwa = gr;
          mwd = gd;
        end
        if (iss && !(ZD && bus.issue_reg == 0)) mbusy[bus.issue_reg] = 1'b1;
      end
      tick();
      chk($sformatf("rnd_we[%0d]", n), bus.rf_we, mwe);
      chk($sformatf("rnd_waddr[%0d]", n), bus.rf_waddr, mwa);
      chk($sformatf("rnd_wdata[%0d]", n), bus.rf_wdata, mwd);
      chk($sformatf("rnd_busy[%0d]", n), bus.busy_vec, mbusy);
    end
    rst = 1'b0;
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
